// File: rtl/imem_fetch_unit.sv
// Synchronous instruction memory with a valid/ready fetch port, a registered 1-cycle response,
// flush support, fault reporting and a runtime load port. Optional perf counters: IMEM_PERF_CNT_EN.
module imem_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 64,
  parameter logic [XLEN-1:0] NOP_INSTR   = XLEN'(32'h0000_0013)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [XLEN-1:0]                req_pc,
  input  logic                           flush,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [XLEN-1:0]                resp_instr,
  output logic [XLEN-1:0]                resp_pc,
  output logic [1:0]                     resp_fault,
  input  logic                           prog_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
  input  logic [XLEN-1:0]                prog_data,
  output logic [31:0]                    perf_fetches,
  output logic [31:0]                    perf_faults
);

  localparam int              ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * DEPTH_WORDS);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;

  // Contents survive reset; only the power-on value is defined.
  logic [XLEN-1:0] mem [DEPTH_WORDS] = '{default: NOP_INSTR};

  logic              accept;
  logic [ADDR_W-1:0] fetch_idx;
  logic [1:0]        fetch_fault;
  logic [XLEN-1:0]   fetch_instr;

  assign req_ready = !resp_valid || resp_ready || flush;
  assign accept    = req_valid && req_ready;
  assign fetch_idx = req_pc[ADDR_W+1:2];

  always_comb begin
    fetch_fault = FAULT_OK;
    fetch_instr = NOP_INSTR;
    if (req_pc[1:0] != 2'b00) begin
      fetch_fault = FAULT_ALIGN;
    end else if (req_pc >= MEM_BYTES) begin
      fetch_fault = FAULT_RANGE;
    end else begin
      fetch_instr = mem[fetch_idx];
    end
  end

  // The write lands at the edge, so a same-cycle fetch of that word still captures the old data.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_instr <= NOP_INSTR;
      resp_pc    <= '0;
      resp_fault <= FAULT_OK;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_instr <= fetch_instr;
      resp_pc    <= req_pc;
      resp_fault <= fetch_fault;
    end else if (resp_ready || flush) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef IMEM_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] fault_cnt;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else if (accept) begin
      if (fetch_cnt != 32'hFFFF_FFFF) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if ((fetch_fault != FAULT_OK) && (fault_cnt != 32'hFFFF_FFFF)) begin
        fault_cnt <= fault_cnt + 32'd1;
      end
    end
  end

  assign perf_fetches = fetch_cnt;
  assign perf_faults  = fault_cnt;
`else
  assign perf_fetches = '0;
  assign perf_faults  = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Table-driven bench for imem_fetch_unit: load, fetch, backpressure, flush, faults, collision,
// reset retention and perf counters.
module tb_imem_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h00B0_0093;
  localparam logic [31:0] I1  = 32'h0020_81B3;
  localparam logic [31:0] I2  = 32'h0011_8233;
  localparam logic [31:0] I3  = 32'h0040_2623;
  localparam logic [31:0] WA  = 32'h1111_1111;
  localparam logic [31:0] WB  = 32'h2222_2222;
  localparam logic [31:0] WT  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_pc;
  logic [1:0]  resp_fault;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] perf_fetches;
  logic [31:0] perf_faults;

  int checks = 0;
  int errors = 0;
  int model_fetches = 0;
  int model_faults = 0;

  typedef struct {
    string       name;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        resp_ready;
    logic        flush;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vecs[$];

  imem_fetch_unit #(.XLEN(32), .DEPTH_WORDS(64), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pc       (req_pc),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_instr   (resp_instr),
    .resp_pc      (resp_pc),
    .resp_fault   (resp_fault),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .perf_fetches (perf_fetches),
    .perf_faults  (perf_faults)
  );

  always #5 clk = ~clk;

  function automatic vec_t makeVec(string name, logic rv, logic [31:0] pc, logic rr, logic fl,
                                   logic we, logic [5:0] wa, logic [31:0] wd, logic e_rdy,
                                   logic e_v, logic [31:0] e_i, logic [31:0] e_pc, logic [1:0] e_f);
    vec_t v;
    v.name = name; v.req_valid = rv; v.req_pc = pc; v.resp_ready = rr; v.flush = fl;
    v.prog_we = we; v.prog_addr = wa; v.prog_data = wd; v.exp_ready = e_rdy;
    v.exp_valid = e_v; v.exp_instr = e_i; v.exp_pc = e_pc; v.exp_fault = e_f;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    req_valid  = v.req_valid;
    req_pc     = v.req_pc;
    resp_ready = v.resp_ready;
    flush      = v.flush;
    prog_we    = v.prog_we;
    prog_addr  = v.prog_addr;
    prog_data  = v.prog_data;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkPerf(input string tag);
    logic [31:0] exp_f;
    logic [31:0] exp_x;
`ifdef IMEM_PERF_CNT_EN
    exp_f = model_fetches;
    exp_x = model_faults;
`else
    exp_f = 32'd0;
    exp_x = 32'd0;
`endif
    checkOutput({tag, ".perf_fetches"}, perf_fetches, exp_f);
    checkOutput({tag, ".perf_faults"}, perf_faults, exp_x);
  endtask

  task automatic runVecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput({vecs[i].name, ".req_ready"}, {31'b0, req_ready}, {31'b0, vecs[i].exp_ready});
      if (vecs[i].req_valid && vecs[i].exp_ready) begin
        model_fetches++;
        if (vecs[i].exp_fault != 2'b00) model_faults++;
      end
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, ".resp_valid"}, {31'b0, resp_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput({vecs[i].name, ".resp_instr"}, resp_instr, vecs[i].exp_instr);
      checkOutput({vecs[i].name, ".resp_pc"}, resp_pc, vecs[i].exp_pc);
      checkOutput({vecs[i].name, ".resp_fault"}, {30'b0, resp_fault}, {30'b0, vecs[i].exp_fault});
    end
  endtask

  initial begin
    int n_main;

    //                  name           rv  pc            rr  fl  we  wa     wd     rdy v   instr pc            fault
    vecs.push_back(makeVec("load0",     0, 32'd0,        1,  0,  1,  6'd0,  I0,    1,  0,  NOP,  32'd0,        2'b00));
    vecs.push_back(makeVec("load1",     0, 32'd0,        1,  0,  1,  6'd1,  I1,    1,  0,  NOP,  32'd0,        2'b00));
    vecs.push_back(makeVec("load2",     0, 32'd0,        1,  0,  1,  6'd2,  I2,    1,  0,  NOP,  32'd0,        2'b00));
    vecs.push_back(makeVec("load3",     0, 32'd0,        1,  0,  1,  6'd3,  I3,    1,  0,  NOP,  32'd0,        2'b00));
    vecs.push_back(makeVec("fetch_pc0", 1, 32'd0,        1,  0,  0,  6'd0,  0,     1,  1,  I0,   32'd0,        2'b00));
    vecs.push_back(makeVec("fetch_pc4", 1, 32'd4,        1,  0,  0,  6'd0,  0,     1,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("fetch_pc8", 1, 32'd8,        1,  0,  0,  6'd0,  0,     1,  1,  I2,   32'd8,        2'b00));
    vecs.push_back(makeVec("fetch_pc12",1, 32'd12,       1,  0,  0,  6'd0,  0,     1,  1,  I3,   32'd12,       2'b00));
    vecs.push_back(makeVec("drain",     0, 32'd0,        1,  0,  0,  6'd0,  0,     1,  0,  I3,   32'd12,       2'b00));
    vecs.push_back(makeVec("bp_pc4",    1, 32'd4,        0,  0,  0,  6'd0,  0,     1,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("bp_stall1", 1, 32'd8,        0,  0,  0,  6'd0,  0,     0,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("bp_stall2", 1, 32'd8,        0,  0,  0,  6'd0,  0,     0,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("bp_stall3", 1, 32'd8,        0,  0,  0,  6'd0,  0,     0,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("bp_accept", 1, 32'd8,        1,  0,  0,  6'd0,  0,     1,  1,  I2,   32'd8,        2'b00));
    vecs.push_back(makeVec("fl_stall",  0, 32'd0,        0,  0,  0,  6'd0,  0,     0,  1,  I2,   32'd8,        2'b00));
    vecs.push_back(makeVec("fl_req24",  1, 32'd24,       0,  1,  0,  6'd0,  0,     1,  1,  NOP,  32'd24,       2'b00));
    vecs.push_back(makeVec("fl_noreq",  0, 32'd0,        0,  1,  0,  6'd0,  0,     1,  0,  NOP,  32'd24,       2'b00));
    vecs.push_back(makeVec("flt_pc2",   1, 32'd2,        1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'd2,        2'b01));
    vecs.push_back(makeVec("flt_pc256", 1, 32'd256,      1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'd256,      2'b10));
    vecs.push_back(makeVec("flt_pc258", 1, 32'd258,      1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'd258,      2'b01));
    vecs.push_back(makeVec("flt_high",  1, 32'hFFFFFFFC, 1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'hFFFFFFFC, 2'b10));
    vecs.push_back(makeVec("wr_top",    1, 32'd0,        1,  0,  1,  6'd63, WT,    1,  1,  I0,   32'd0,        2'b00));
    vecs.push_back(makeVec("fetch_top", 1, 32'd252,      1,  0,  0,  6'd0,  0,     1,  1,  WT,   32'd252,      2'b00));
    vecs.push_back(makeVec("col_wrA",   0, 32'd0,        1,  0,  1,  6'd5,  WA,    1,  0,  WT,   32'd252,      2'b00));
    vecs.push_back(makeVec("col_same",  1, 32'd20,       1,  0,  1,  6'd5,  WB,    1,  1,  WA,   32'd20,       2'b00));
    vecs.push_back(makeVec("col_next",  1, 32'd20,       1,  0,  0,  6'd0,  0,     1,  1,  WB,   32'd20,       2'b00));
    vecs.push_back(makeVec("rst_stall", 0, 32'd0,        0,  0,  0,  6'd0,  0,     0,  1,  WB,   32'd20,       2'b00));
    n_main = vecs.size();
    vecs.push_back(makeVec("pf_pc4",    1, 32'd4,        1,  0,  0,  6'd0,  0,     1,  1,  I1,   32'd4,        2'b00));
    vecs.push_back(makeVec("pf_pc2",    1, 32'd2,        1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'd2,        2'b01));
    vecs.push_back(makeVec("pf_pc20",   1, 32'd20,       1,  0,  0,  6'd0,  0,     1,  1,  WB,   32'd20,       2'b00));
    vecs.push_back(makeVec("pf_pc256",  1, 32'd256,      1,  0,  0,  6'd0,  0,     1,  1,  NOP,  32'd256,      2'b10));
    vecs.push_back(makeVec("pf_pc12",   1, 32'd12,       1,  0,  0,  6'd0,  0,     1,  1,  I3,   32'd12,       2'b00));
    vecs.push_back(makeVec("pf_idle",   0, 32'd0,        1,  0,  0,  6'd0,  0,     1,  0,  I3,   32'd12,       2'b00));

    rst_n = 1'b0;
    applyStimulus(makeVec("idle", 0, 32'd0, 0, 0, 0, 6'd0, 0, 0, 0, NOP, 32'd0, 2'b00));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("reset.resp_instr", resp_instr, NOP);
    checkOutput("reset.resp_pc", resp_pc, 32'd0);
    checkOutput("reset.resp_fault", {30'b0, resp_fault}, 32'd0);
    checkPerf("reset");
    rst_n = 1'b1;

    runVecs(0, n_main);
    @(negedge clk);
    checkPerf("main_table");

    // Reset lands while a response is stalled; it must clear at once and leave memory intact.
    rst_n = 1'b0;
    #1;
    checkOutput("mid_stall_rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("mid_stall_rst.resp_instr", resp_instr, NOP);
    checkOutput("mid_stall_rst.resp_pc", resp_pc, 32'd0);
    model_fetches = 0;
    model_faults  = 0;
    checkPerf("mid_stall_rst");
    @(negedge clk);
    rst_n = 1'b1;

    runVecs(n_main, vecs.size());
    @(negedge clk);
    checkPerf("after_5_fetches");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
